// File: rtl/adc_serial_responder.sv
// Device end of the serial ADC link: serves a held sample or an internal ramp on adc_sd.
// adc_sd follows pin-level adc_clk/adc_cs falls by 3 clk; sample_ready drops while a sample is held unsent.
module adc_serial_responder #(
    parameter int SAMPLE_WIDTH = 12,
    parameter int LEAD_ZEROS   = 4,
    parameter int RAMP_STEP    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    adc_clk,
    input  logic                    adc_cs,
    output logic                    adc_sd,
    output logic                    adc_sd_oe,
    input  logic                    pattern_mode,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    frame_done,
    output logic                    frame_abort,
    output logic                    underrun
);
    localparam int FRAME_LEN = LEAD_ZEROS + SAMPLE_WIDTH;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [1:0]              r_clk_sync;
    logic [1:0]              r_cs_sync;
    logic                    r_clk_prev;
    logic                    r_cs_prev;
    logic [FRAME_LEN-2:0]    r_shift;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sd;
    logic                    r_oe;
    logic                    r_done;
    logic                    r_abort;
    logic                    r_underrun;
    logic [SAMPLE_WIDTH-1:0] r_hold;
    logic                    r_fresh;
    logic [SAMPLE_WIDTH-1:0] r_ramp;

    logic                    w_clk_fall;
    logic                    w_cs_fall;
    logic                    w_cs_rise;
    logic                    w_start;
    logic                    w_shift;
    logic                    w_end;
    logic                    w_abort;
    logic                    w_xfer;
    logic [SAMPLE_WIDTH-1:0] w_word;
    logic [FRAME_LEN-1:0]    w_frame;

    // Both link inputs idle high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync <= 2'b11;
            r_cs_sync  <= 2'b11;
            r_clk_prev <= 1'b1;
            r_cs_prev  <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], adc_clk};
            r_cs_sync  <= {r_cs_sync[0], adc_cs};
            r_clk_prev <= r_clk_sync[1];
            r_cs_prev  <= r_cs_sync[1];
        end
    end

    assign w_clk_fall = r_clk_prev & ~r_clk_sync[1] & ~r_cs_sync[1];
    assign w_cs_fall  = r_cs_prev & ~r_cs_sync[1];
    assign w_cs_rise  = ~r_cs_prev & r_cs_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_cs_fall) w_state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_clk_fall && (r_cnt == LAST_CNT)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  if (w_cs_rise) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // cs edges take priority over a clk fall landing in the same cycle.
    always_comb begin
        w_start = 1'b0;
        w_shift = 1'b0;
        w_end   = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            ST_IDLE:  w_start = w_cs_fall;
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_abort = 1'b1;
                end else if (w_clk_fall) begin
                    if (r_cnt == LAST_CNT) begin
                        w_end = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign w_xfer  = sample_valid & ~r_fresh;
    assign w_word  = pattern_mode ? r_ramp : r_hold;
    assign w_frame = {{LEAD_ZEROS{1'b0}}, w_word};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_sd       <= 1'b0;
            r_oe       <= 1'b0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
            r_underrun <= 1'b0;
            r_ramp     <= '0;
        end else begin
            r_done  <= w_end;
            r_abort <= w_abort;
            if (w_start) begin
                r_shift <= w_frame[FRAME_LEN-2:0];
                r_sd    <= w_frame[FRAME_LEN-1];
                r_oe    <= 1'b1;
                r_cnt   <= CNT_W'(1);
                if (!pattern_mode && !r_fresh) begin
                    r_underrun <= 1'b1;
                end
            end else if (w_shift) begin
                r_sd    <= r_shift[FRAME_LEN-2];
                r_shift <= {r_shift[FRAME_LEN-3:0], 1'b0};
                r_cnt   <= r_cnt + CNT_W'(1);
            end else if (w_end || w_abort) begin
                r_sd  <= 1'b0;
                r_oe  <= 1'b0;
                r_cnt <= '0;
            end
            if (w_end && pattern_mode) begin
                r_ramp <= r_ramp + SAMPLE_WIDTH'(RAMP_STEP);
            end
        end
    end

    // A load coinciding with frame start lands after the old word was taken, so it stays fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold  <= '0;
            r_fresh <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_hold <= sample_in;
            end
            if (w_xfer) begin
                r_fresh <= 1'b1;
            end else if (w_start && !pattern_mode) begin
                r_fresh <= 1'b0;
            end
        end
    end

    assign adc_sd       = r_sd;
    assign adc_sd_oe    = r_oe;
    assign sample_ready = ~r_fresh;
    assign frame_done   = r_done;
    assign frame_abort  = r_abort;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Bench for adc_serial_responder: table vectors, corner sequences and random frames vs. a word-level model.
module tb_adc_serial_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        adc_clk = 1'b1;
    logic        adc_cs = 1'b1;
    logic        adc_sd;
    logic        adc_sd_oe;
    logic        pattern_mode = 1'b0;
    logic [11:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        frame_done;
    logic        frame_abort;
    logic        underrun;

    adc_serial_responder #(.SAMPLE_WIDTH(12), .LEAD_ZEROS(4), .RAMP_STEP(1)) dut (
        .clk(clk), .reset(reset), .adc_clk(adc_clk), .adc_cs(adc_cs),
        .adc_sd(adc_sd), .adc_sd_oe(adc_sd_oe), .pattern_mode(pattern_mode),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .frame_done(frame_done), .frame_abort(frame_abort), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_total = 0;
    int abort_total = 0;

    always @(negedge clk) begin
        if (frame_done) done_total++;
        if (frame_abort) abort_total++;
    end

    // Word-level model of what the initiator should see.
    logic [11:0] m_ramp, m_hold;
    bit          m_fresh, m_under;

    // Results of the last run_frame call.
    logic [15:0] f_word;
    bit          f_oe_ok;
    logic        f_oe_end, f_rst_sd, f_rst_oe;
    int          f_done, f_abort;

    typedef struct {
        bit          mode;
        bit          do_load;
        logic [11:0] val;
        logic [15:0] exp_word;
        bit          exp_under;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_reset();
        m_ramp = '0; m_hold = '0; m_fresh = 0; m_under = 0;
    endtask

    task automatic m_start(input bit mode, output logic [15:0] word);
        word = {4'h0, mode ? m_ramp : m_hold};
        if (!mode) begin
            if (!m_fresh) m_under = 1;
            m_fresh = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; adc_cs = 1'b1; adc_clk = 1'b1; sample_valid = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(3);
        m_reset();
    endtask

    task automatic load(input logic [11:0] v, output bit acc);
        acc = 0;
        sample_in = v;
        sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (sample_ready) begin
                acc = 1;
                tick(1);
                break;
            end
            tick(1);
        end
        sample_valid = 1'b0;
    endtask

    // Initiator: 16 clocks of clk/8; each bit is taken just before the falling edge that retires it.
    // cut_at >= 0 stops after that many falls, by raising adc_cs or (cut_rst) by asserting reset.
    task automatic run_frame(input int cut_at, input bit cut_rst);
        int d0, a0;
        d0 = done_total;
        a0 = abort_total;
        f_word = '0;
        f_oe_ok = 1;
        f_oe_end = 1'bx;
        adc_cs = 1'b0;
        tick(6);
        for (int b = 0; b < 16; b++) begin
            if (b == cut_at) begin
                if (cut_rst) begin
                    reset = 1'b1;
                    #1;
                    f_rst_sd = adc_sd;
                    f_rst_oe = adc_sd_oe;
                    adc_cs = 1'b1;
                    adc_clk = 1'b1;
                    @(negedge clk);
                    tick(2);
                    reset = 1'b0;
                    tick(4);
                end else begin
                    adc_cs = 1'b1;
                    tick(3);
                    f_oe_end = adc_sd_oe;
                    tick(8);
                end
                f_done = done_total - d0;
                f_abort = abort_total - a0;
                return;
            end
            f_word = {f_word[14:0], adc_sd};
            if (adc_sd_oe !== 1'b1) f_oe_ok = 0;
            adc_clk = 1'b0;
            tick(4);
            adc_clk = 1'b1;
            tick(4);
        end
        f_oe_end = adc_sd_oe;
        tick(2);
        adc_cs = 1'b1;
        tick(8);
        f_done = done_total - d0;
        f_abort = abort_total - a0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] exp;
        bit          acc, inj_acc, mode;
        logic [11:0] v;
        int          cut;

        tbl[0] = '{mode: 0, do_load: 1, val: 12'hA5C, exp_word: 16'h0A5C, exp_under: 0};
        tbl[1] = '{mode: 1, do_load: 0, val: 12'h000, exp_word: 16'h0000, exp_under: 0};
        tbl[2] = '{mode: 1, do_load: 0, val: 12'h000, exp_word: 16'h0001, exp_under: 0};
        tbl[3] = '{mode: 1, do_load: 0, val: 12'h000, exp_word: 16'h0002, exp_under: 0};
        tbl[4] = '{mode: 0, do_load: 0, val: 12'h000, exp_word: 16'h0A5C, exp_under: 1};
        tbl[5] = '{mode: 0, do_load: 1, val: 12'h7FF, exp_word: 16'h07FF, exp_under: 1};
        tbl[6] = '{mode: 1, do_load: 0, val: 12'h000, exp_word: 16'h0003, exp_under: 1};

        do_reset();
        chk("rst_sd", adc_sd, 0);
        chk("rst_oe", adc_sd_oe, 0);
        chk("rst_ready", sample_ready, 1);
        chk("rst_done", frame_done, 0);
        chk("rst_abort", frame_abort, 0);
        chk("rst_underrun", underrun, 0);

        // Holding mode with no sample since reset: stale zero word and a sticky underrun.
        pattern_mode = 1'b0;
        run_frame(-1, 0);
        chk("under_word", f_word, 16'h0000);
        chk("under_flag", underrun, 1);
        load(12'h321, acc);
        chk("under_load_acc", acc, 1);
        chk("under_sticky", underrun, 1);

        do_reset();
        for (int i = 0; i < 7; i++) begin
            pattern_mode = tbl[i].mode;
            if (tbl[i].do_load) begin
                load(tbl[i].val, acc);
                chk($sformatf("tbl%0d_acc", i), acc, 1);
                chk($sformatf("tbl%0d_ready_lo", i), sample_ready, 0);
                if (acc) begin m_hold = tbl[i].val; m_fresh = 1; end
            end
            m_start(tbl[i].mode, exp);
            run_frame(-1, 0);
            if (tbl[i].mode) m_ramp = m_ramp + 12'd1;
            chk($sformatf("tbl%0d_word", i), f_word, tbl[i].exp_word);
            chk($sformatf("tbl%0d_done", i), f_done, 1);
            chk($sformatf("tbl%0d_underrun", i), underrun, tbl[i].exp_under);
            chk($sformatf("tbl%0d_ready", i), sample_ready, 1);
            chk($sformatf("tbl%0d_oe_on", i), f_oe_ok, 1);
            chk($sformatf("tbl%0d_oe_off", i), f_oe_end, 0);
        end

        // Ramp wrap.
        force dut.r_ramp = 12'hFFF;
        tick(1);
        release dut.r_ramp;
        m_ramp = 12'hFFF;
        pattern_mode = 1'b1;
        run_frame(-1, 0);
        chk("wrap_fff", f_word, 16'h0FFF);
        m_ramp = m_ramp + 12'd1;
        run_frame(-1, 0);
        chk("wrap_000", f_word, 16'h0000);
        m_ramp = m_ramp + 12'd1;

        // Abort after 7 clocks: ramp must not advance.
        run_frame(7, 0);
        chk("abort_pulse", f_abort, 1);
        chk("abort_no_done", f_done, 0);
        chk("abort_oe_off", f_oe_end, 0);
        run_frame(-1, 0);
        chk("abort_next_word", f_word, {4'h0, m_ramp});
        chk("abort_next_done", f_done, 1);
        m_ramp = m_ramp + 12'd1;

        // New sample offered in the frame-start cycle while an older one is still held.
        do_reset();
        pattern_mode = 1'b0;
        load(12'h456, acc);
        chk("sc_load456", acc, 1);
        fork
            run_frame(-1, 0);
            begin
                tick(2);
                load(12'h123, inj_acc);
            end
        join
        chk("sc_word456", f_word, 16'h0456);
        chk("sc_inj_acc", inj_acc, 1);
        chk("sc_ready_lo", sample_ready, 0);
        run_frame(-1, 0);
        chk("sc_word123", f_word, 16'h0123);
        chk("sc_ready_hi", sample_ready, 1);
        chk("sc_underrun", underrun, 0);

        // Reset after the 9th clk fall.
        load(12'h0F0, acc);
        run_frame(9, 1);
        chk("mr_sd", f_rst_sd, 0);
        chk("mr_oe", f_rst_oe, 0);
        m_reset();
        load(12'h7FF, acc);
        chk("mr_load", acc, 1);
        run_frame(-1, 0);
        chk("mr_word", f_word, 16'h07FF);
        chk("mr_done", f_done, 1);

        // Random frames against the model.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            mode = 1'($urandom_range(0, 1));
            pattern_mode = mode;
            if ($urandom_range(0, 2) != 0) begin
                v = 12'($urandom);
                load(v, acc);
                chk($sformatf("rnd%0d_acc", n), acc, !m_fresh);
                if (acc) begin m_hold = v; m_fresh = 1; end
            end
            cut = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : -1;
            m_start(mode, exp);
            run_frame(cut, 0);
            if (cut < 0) begin
                if (mode) m_ramp = m_ramp + 12'd1;
                chk($sformatf("rnd%0d_word", n), f_word, exp);
                chk($sformatf("rnd%0d_done", n), f_done, 1);
            end else begin
                chk($sformatf("rnd%0d_abort", n), f_abort, 1);
                chk($sformatf("rnd%0d_no_done", n), f_done, 0);
                chk($sformatf("rnd%0d_abort_oe", n), f_oe_end, 0);
            end
            chk($sformatf("rnd%0d_underrun", n), underrun, m_under);
            chk($sformatf("rnd%0d_ready", n), sample_ready, !m_fresh);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
